// File: rtl/ntt_addr_seq.sv
// ntt_addr_seq
// ----------------------------------------------------------------------------
// Consumer-side sequencer for the 128-entry NTT address ROM. On start it walks
// ROM addresses 0..NUM_STEPS-1, absorbs the one-cycle ROM read latency, and
// streams each ROM word out as four 7-bit coefficient indices, one step per
// beat, to the butterfly datapath.
//
// Ports
//   clk, rst        : single rising-edge clock, synchronous active-high reset
//   start           : run request, sampled only while idle
//   busy            : high while a run is in progress (RUN or DRAIN)
//   done            : one-cycle pulse together with the pop of the last step
//   rom_addr        : ROM address (the issue counter register)
//   rom_ena         : ROM read strobe; data for it is on rom_data next cycle
//   rom_data        : ROM read word, four packed 7-bit indices
//   out_valid       : a step is available at the FIFO head
//   out_ready       : downstream accepts the current beat
//   out_step        : step index of the current beat
//   out_a0..out_a3  : rom_data[27:21] / [20:14] / [13:7] / [6:0] of that step
//   state_dbg       : FSM state (0 IDLE, 1 RUN, 2 DRAIN) for observation
//   stall_cnt       : only with ADDR_SEQ_PERF_EN defined; saturating count of
//                     cycles with out_valid & !out_ready during a run
//
// Handshake: a beat transfers in every cycle where out_valid & out_ready are
// both high; while out_valid is high and out_ready low, every out_* field is
// held unchanged.
//
// Configuration macro: ADDR_SEQ_PERF_EN (adds the stall_cnt output).
// ----------------------------------------------------------------------------
module ntt_addr_seq #(
  parameter int NUM_STEPS  = 128,
  parameter int DATA_WIDTH = 28,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [6:0]            rom_addr,
  output logic                  rom_ena,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_step,
  output logic [6:0]            out_a0,
  output logic [6:0]            out_a1,
  output logic [6:0]            out_a2,
  output logic [6:0]            out_a3,
  output logic [1:0]            state_dbg
`ifdef ADDR_SEQ_PERF_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int EW = 7 + DATA_WIDTH;  // FIFO entry: {step tag, rom word}

  state_t         state, state_nxt;
  logic [6:0]     iss;        // next address to issue
  logic [6:0]     tag;        // step index of the read in flight
  logic           inflight;   // rom_ena of the previous cycle
  logic [EW-1:0]  mem [2];
  logic           rd_ptr, wr_ptr;
  logic [1:0]     occ;
  logic [2:0]     credit_sum;
  logic [EW-1:0]  head;
  logic           pop, issue, last_iss, done_c;

  assign pop        = out_valid & out_ready;
  // Entries the FIFO will hold at the end of this cycle; a read issued now
  // lands one cycle later, so it must fit on top of that.
  assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign last_iss   = (iss == 7'(NUM_STEPS - 1));
  assign issue      = (state == RUN) && (credit_sum < 3'(FIFO_DEPTH));
  // In DRAIN every read has been issued; one entry left with nothing in
  // flight is the last step.
  assign done_c     = (state == DRAIN) && !inflight && (occ == 2'd1) && pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && last_iss) state_nxt = DRAIN;
      DRAIN:   if (done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iss      <= '0;
      tag      <= '0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) begin
        tag <= iss;
        iss <= last_iss ? 7'd0 : iss + 7'd1;
      end
      if (inflight) begin
        mem[wr_ptr] <= {tag, rom_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign done      = done_c;
  assign rom_ena   = issue;
  assign rom_addr  = iss;
  assign out_valid = (occ != 2'd0);
  assign out_step  = head[EW-1 -: 7];
  assign out_a0    = head[DATA_WIDTH-1  -: 7];
  assign out_a1    = head[DATA_WIDTH-8  -: 7];
  assign out_a2    = head[DATA_WIDTH-15 -: 7];
  assign out_a3    = head[DATA_WIDTH-22 -: 7];
  assign state_dbg = state;

`ifdef ADDR_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Testbench for ntt_addr_seq: a 128-step instance and a 4-step instance share
// clock and reset; a behavioural ROM with a one-cycle registered read feeds
// each. Every scenario task drives a run and compares its observations.
module tb_ntt_addr_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // ---------------- 128-step instance ----------------
  logic        start = 1'b0, out_ready = 1'b0;
  logic [27:0] rom_data = '0;
  logic        busy, done, rom_ena, out_valid;
  logic [6:0]  rom_addr, out_step, out_a0, out_a1, out_a2, out_a3;
  logic [1:0]  state_dbg;
  logic [27:0] pay;
  assign pay = {out_a0, out_a1, out_a2, out_a3};
`ifdef ADDR_SEQ_PERF_EN
  logic [15:0] stall_cnt, stall_cnt_b;
`endif

  ntt_addr_seq dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_ena(rom_ena), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_step(out_step),
    .out_a0(out_a0), .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3),
    .state_dbg(state_dbg)
`ifdef ADDR_SEQ_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- 4-step instance ----------------
  logic        start_b = 1'b0, ready_b = 1'b1;
  logic [27:0] rom_data_b = '0;
  logic        busy_b, done_b, rom_ena_b, valid_b;
  logic [6:0]  rom_addr_b, step_b, a0_b, a1_b, a2_b, a3_b;
  logic [1:0]  state_b;

  ntt_addr_seq #(.NUM_STEPS(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rom_addr(rom_addr_b), .rom_ena(rom_ena_b), .rom_data(rom_data_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_step(step_b),
    .out_a0(a0_b), .out_a1(a1_b), .out_a2(a2_b), .out_a3(a3_b),
    .state_dbg(state_b)
`ifdef ADDR_SEQ_PERF_EN
    , .stall_cnt(stall_cnt_b)
`endif
  );

  // ---------------- ROM model ----------------
  function automatic logic [27:0] rom_word(input logic [6:0] a);
    case (a)
      7'd0:    rom_word = {7'd1,  7'd9,  7'd0,  7'd0};
      7'd1:    rom_word = {7'd3,  7'd11, 7'd0,  7'd0};
      7'd2:    rom_word = {7'd5,  7'd13, 7'd0,  7'd0};
      7'd3:    rom_word = {7'd7,  7'd15, 7'd0,  7'd0};
      7'd32:   rom_word = {7'd4,  7'd4,  7'd66, 7'd2};
      7'd127:  rom_word = {7'd64, 7'd64, 7'd96, 7'd32};
      default: rom_word = {a, a ^ 7'h2a, ~a, a + 7'd5};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rom_ena)   rom_data   <= rom_word(rom_addr);
    if (rom_ena_b) rom_data_b <= rom_word(rom_addr_b);
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  // observations collected by drive_run
  int beats, done_cyc, done_cnt, order_bad, stable_bad, credit_bad, valid_bad;
  int reads, busy_after;
  bit ena_k1, step0_k3, b2b_ok, rst_hit, done_pop;

  // ---------------- driver ----------------
  // mode 0: out_ready high; 1: random out_ready; 2: out_ready low in cycles 3..22.
  // Cycle k=0 is the cycle in which start is sampled.
  task automatic drive_run(input int mode, input int mid_start,
                           input int rst_step, input bit b2b);
    int occ_m, infl_m, exp_step;
    bit held, p;
    logic [34:0] held_v;
    beats = 0; done_cyc = -1; done_cnt = 0; order_bad = 0; stable_bad = 0;
    credit_bad = 0; valid_bad = 0; reads = 0; busy_after = -1;
    ena_k1 = 0; step0_k3 = 0; b2b_ok = 0; rst_hit = 0; done_pop = 0;
    occ_m = 0; infl_m = 0; exp_step = 0; held = 0; held_v = '0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start = (k == 0) || (k == mid_start) ||
              (b2b && done_cyc >= 0 && k == done_cyc + 1);
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = !(k >= 3 && k < 23);
        default: out_ready = 1'b1;
      endcase
      #1;
      p = out_valid && out_ready;
      if (k == 1) ena_k1 = rom_ena && (rom_addr == 7'd0);
      if (k == 3) step0_k3 = out_valid && (out_step == 7'd0) && (pay == rom_word(7'd0));
      if (rom_ena && (occ_m - int'(p) + infl_m >= 2)) credit_bad++;
      if (out_valid !== (occ_m != 0)) valid_bad++;
      if (held && {out_step, pay} !== held_v) stable_bad++;
      held   = out_valid && !out_ready;
      held_v = {out_step, pay};
      if (p) begin
        if (out_step !== 7'(exp_step) || pay !== rom_word(7'(exp_step))) order_bad++;
        exp_step++;
        beats++;
      end
      if (k < 23 && rom_ena) reads++;
      if (done) begin
        done_cnt++;
        done_cyc = k;
        done_pop = p;
      end
      if (done_cyc >= 0 && k == done_cyc + 1) busy_after = int'(busy);
      if (b2b && done_cyc >= 0 && k == done_cyc + 2) b2b_ok = rom_ena && (rom_addr == 7'd0);
      occ_m  = occ_m - int'(p) + infl_m;
      infl_m = int'(rom_ena);
      if (rst_step >= 0 && p && out_step == 7'(rst_step)) begin
        rst = 1'b1;
        rst_hit = 1;
        break;
      end
      if (done_cyc >= 0 && k == done_cyc + (b2b ? 2 : 1)) break;
    end
    start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passes++;
    checks++; if (rom_ena !== 1'b0) $display("FAIL reset_rom_ena got %b exp 0", rom_ena); else passes++;
    checks++; if (rom_addr !== 7'd0) $display("FAIL reset_rom_addr got %0d exp 0", rom_addr); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
    checks++; if (out_step !== 7'd0) $display("FAIL reset_out_step got %0d exp 0", out_step); else passes++;
    checks++; if (pay !== 28'd0) $display("FAIL reset_fields got %h exp 0", pay); else passes++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_dbg); else passes++;
    // out_ready high in IDLE must do nothing
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_ready got valid=%b busy=%b exp 0 0", out_valid, busy); else passes++;
    checks++; if (valid_b !== 1'b0 || busy_b !== 1'b0)
      $display("FAIL reset_b got valid=%b busy=%b exp 0 0", valid_b, busy_b); else passes++;
  endtask

  task automatic test_full_rate();
    drive_run(0, -1, -1, 1'b0);
    checks++; if (ena_k1 !== 1'b1) $display("FAIL full_first_issue got %b exp 1", ena_k1); else passes++;
    checks++; if (step0_k3 !== 1'b1) $display("FAIL full_step0_T3 got %b exp 1", step0_k3); else passes++;
    checks++; if (beats !== 128) $display("FAIL full_beats got %0d exp 128", beats); else passes++;
    checks++; if (order_bad !== 0) $display("FAIL full_order got %0d bad beats exp 0", order_bad); else passes++;
    checks++; if (done_cyc !== 130) $display("FAIL full_done_cycle got %0d exp 130", done_cyc); else passes++;
    checks++; if (done_cnt !== 1 || done_pop !== 1'b1)
      $display("FAIL full_done_pulse got cnt=%0d pop=%b exp 1 1", done_cnt, done_pop); else passes++;
    checks++; if (busy_after !== 0) $display("FAIL full_busy_after got %0d exp 0", busy_after); else passes++;
    checks++; if (valid_bad !== 0) $display("FAIL full_valid_model got %0d exp 0", valid_bad); else passes++;
    checks++; if (credit_bad !== 0) $display("FAIL full_credit got %0d exp 0", credit_bad); else passes++;
  endtask

  task automatic test_random_ready();
    drive_run(1, -1, -1, 1'b0);
    checks++; if (beats !== 128) $display("FAIL rand_beats got %0d exp 128", beats); else passes++;
    checks++; if (order_bad !== 0) $display("FAIL rand_order got %0d exp 0", order_bad); else passes++;
    checks++; if (stable_bad !== 0) $display("FAIL rand_stable got %0d exp 0", stable_bad); else passes++;
    checks++; if (credit_bad !== 0) $display("FAIL rand_credit got %0d exp 0", credit_bad); else passes++;
    checks++; if (valid_bad !== 0) $display("FAIL rand_valid_model got %0d exp 0", valid_bad); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL rand_done_cnt got %0d exp 1", done_cnt); else passes++;
  endtask

  task automatic test_stall();
    drive_run(2, -1, -1, 1'b0);
    checks++; if (reads !== 2) $display("FAIL stall_reads got %0d exp 2", reads); else passes++;
    checks++; if (order_bad !== 0) $display("FAIL stall_order got %0d exp 0", order_bad); else passes++;
    checks++; if (beats !== 128) $display("FAIL stall_beats got %0d exp 128", beats); else passes++;
    checks++; if (stable_bad !== 0) $display("FAIL stall_stable got %0d exp 0", stable_bad); else passes++;
    checks++; if (done_cyc !== 150) $display("FAIL stall_done_cycle got %0d exp 150", done_cyc); else passes++;
`ifdef ADDR_SEQ_PERF_EN
    checks++; if (stall_cnt !== 16'd20) $display("FAIL stall_cnt got %0d exp 20", stall_cnt); else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    drive_run(0, -1, 50, 1'b0);
    checks++; if (rst_hit !== 1'b1) $display("FAIL rstmid_reached got %b exp 1", rst_hit); else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({busy, done, rom_ena, out_valid} !== 4'b0000)
      $display("FAIL rstmid_flags got %b exp 0000", {busy, done, rom_ena, out_valid}); else passes++;
    checks++; if ({rom_addr, out_step, pay} !== 42'd0)
      $display("FAIL rstmid_values got %h exp 0", {rom_addr, out_step, pay}); else passes++;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_late_word got valid=%b exp 0", out_valid); else passes++;
    drive_run(0, -1, -1, 1'b0);
    checks++; if (step0_k3 !== 1'b1) $display("FAIL rstmid_restart got %b exp 1", step0_k3); else passes++;
    checks++; if (beats !== 128 || order_bad !== 0)
      $display("FAIL rstmid_rerun got beats=%0d bad=%0d exp 128 0", beats, order_bad); else passes++;
  endtask

  task automatic test_start_midrun();
    drive_run(0, 40, -1, 1'b0);
    checks++; if (beats !== 128 || order_bad !== 0)
      $display("FAIL midstart_beats got %0d bad=%0d exp 128 0", beats, order_bad); else passes++;
    checks++; if (done_cyc !== 130 || done_cnt !== 1)
      $display("FAIL midstart_done got cyc=%0d cnt=%0d exp 130 1", done_cyc, done_cnt); else passes++;
  endtask

  task automatic test_back_to_back();
    drive_run(0, -1, -1, 1'b1);
    checks++; if (done_cyc !== 130) $display("FAIL b2b_done got %0d exp 130", done_cyc); else passes++;
    checks++; if (busy_after !== 0) $display("FAIL b2b_idle got busy=%0d exp 0", busy_after); else passes++;
    checks++; if (b2b_ok !== 1'b1) $display("FAIL b2b_restart got %b exp 1", b2b_ok); else passes++;
    apply_reset();
  endtask

  task automatic test_short();
    logic [27:0] exp_b [4];
    int n, dcyc, bcyc;
    bit dpop;
    exp_b[0] = {7'd1, 7'd9,  7'd0, 7'd0};
    exp_b[1] = {7'd3, 7'd11, 7'd0, 7'd0};
    exp_b[2] = {7'd5, 7'd13, 7'd0, 7'd0};
    exp_b[3] = {7'd7, 7'd15, 7'd0, 7'd0};
    n = 0; dcyc = -1; bcyc = -1; dpop = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start_b = (k == 0);
      ready_b = 1'b1;
      #1;
      if (valid_b && ready_b) begin
        if (n < 4) begin
          checks++; if (step_b !== 7'(n))
            $display("FAIL short_step%0d got %0d exp %0d", n, step_b, n); else passes++;
          checks++; if ({a0_b, a1_b, a2_b, a3_b} !== exp_b[n])
            $display("FAIL short_fields%0d got %h exp %h", n, {a0_b, a1_b, a2_b, a3_b}, exp_b[n]); else passes++;
        end
        n++;
      end
      if (done_b) begin dcyc = k; dpop = valid_b && ready_b; end
      if (dcyc >= 0 && k == dcyc + 1) begin bcyc = int'(busy_b); break; end
    end
    start_b = 1'b0;
    checks++; if (n !== 4) $display("FAIL short_beats got %0d exp 4", n); else passes++;
    checks++; if (dcyc !== 6 || dpop !== 1'b1)
      $display("FAIL short_done got cyc=%0d pop=%b exp 6 1", dcyc, dpop); else passes++;
    checks++; if (bcyc !== 0) $display("FAIL short_busy_after got %0d exp 0", bcyc); else passes++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_full_rate();
    test_random_ready();
    test_stall();
    test_reset_mid();
    test_start_midrun();
    test_back_to_back();
    test_short();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ntt_addr_seq.md
# ntt_addr_seq

Consumer-side sequencer for the 128-entry NTT address ROM (1-cycle registered read, 28-bit word of four packed 7-bit coefficient indices). On `start` it walks ROM addresses 0..NUM_STEPS-1 and absorbs the one-cycle ROM latency. It unpacks each word into four indices and delivers them one step per beat over a valid/ready stream to the butterfly datapath. Sits between the ROM and the NTT core's bank-access stage.

## Interface
- `NUM_STEPS`, 128, steps per run (1..128).
- `DATA_WIDTH`, 28, ROM word width (4 x 7 bits).
- `FIFO_DEPTH`, 2, output buffer entries (fixed; credit rule below assumes 2).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high in RUN/DRAIN.
- `done`  out  1  1-cycle pulse when the last step is popped.
- `rom_addr`  out  7  ROM address, registered.
- `rom_ena`  out  1  read strobe; ROM word for an address issued in cycle N is on `rom_data` in N+1.
- `rom_data`  in  DATA_WIDTH  ROM read word.
- `out_valid`  out  1  step available.
- `out_ready`  in  1  downstream accepts.
- `out_step`  out  7  step index of current beat.
- `out_a0`/`out_a1`/`out_a2`/`out_a3`  out  7 each  `rom_data[27:21]`/`[20:14]`/`[13:7]`/`[6:0]`.

## Operation
- FSM: IDLE -> RUN on `start`; RUN -> DRAIN after issuing address NUM_STEPS-1; DRAIN -> IDLE when FIFO empty, no read in flight, and the last beat is popped (`done` pulses that cycle).
- Issue counter `iss` (0..NUM_STEPS-1). Issue allowed in cycle N iff state RUN and `occ - pop + inflight < 2`. Here `occ` is FIFO occupancy, `pop = out_valid & out_ready`, and `inflight` = `rom_ena` of the previous cycle. Issue drives `rom_ena`=1, `rom_addr`=`iss`, and `iss`++.
- Capture: when `inflight`=1, the word on `rom_data` and its step tag are written into the FIFO at the end of that cycle. The credit rule guarantees this never overflows.
- Output: head of FIFO drives `out_*`; `out_valid` = FIFO non-empty. Fields and `out_step` are held stable while `out_valid & !out_ready`.
- `start` while busy: ignored. `out_ready` high in IDLE: no effect.
- Reset (any state, including mid-run): state IDLE, `iss`=0, FIFO flushed, `inflight` cleared. Any word returning from the ROM after reset is discarded.
- Reset values: `busy`=0, `done`=0, `rom_ena`=0, `rom_addr`=0, `out_valid`=0, `out_step`=0, `out_a0..a3`=0.

## Timing
- `start` sampled in cycle T: `rom_ena`=1, `rom_addr`=0 in T+1; data in T+2; `out_valid`=1 with step 0 in T+3.
- With `out_ready` held high: one beat per cycle. Step k appears in T+3+k; the last beat (NUM_STEPS=128) is in T+130; `done`=1 in T+130 together with the final pop; `busy`=0 from T+131.
- Backpressure: `out_ready` low stalls issue within one cycle. Never more than 2 buffered plus 1 in flight; never a lost or duplicated step.
- Back-to-back runs: `start` in the cycle after `done` is accepted.

## Configuration
- `ADDR_SEQ_PERF_EN` defined: adds output `stall_cnt` (16 bits). It counts cycles with `out_valid & !out_ready` during a run, saturates at 16'hFFFF, clears on `rst` and on accepted `start`, and holds its value in IDLE.
- Not defined: port absent, no counter logic.

## Test plan
- Reset, `start`, `out_ready`=1 -> step 0 = {1,9,0,0} in T+3; step 32 = {4,4,66,2}; step 127 = {64,64,96,32}; `done` in T+130; 128 beats total, in order.
- `out_ready` toggled pseudo-randomly -> same 128-beat sequence; payload stable while stalled; `rom_ena` never issued with 2 entries occupied.
- `out_ready`=0 for 20 cycles after first valid -> at most 2 reads issued; beats resume with step 0, then step 1; `stall_cnt`=20 when PERF enabled.
- `rst` asserted at step 50 -> next cycle all outputs at reset values; the late ROM word is discarded; new `start` restarts at step 0 = {1,9,0,0}.
- `NUM_STEPS`=4 -> beats {1,9,0,0}, {3,11,0,0}, {5,13,0,0}, {7,15,0,0}; `done` with the 4th pop.
- `start` pulsed mid-run -> ignored; step count and `done` timing unchanged.
